id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register of the 5-stage MIPS core. Captures decoded controls, operands, immediate and

---
 rtl/id_ex_pipe_reg.sv | 131 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded controls and operands at the end of ID, with
// hazard-unit stall (hold), flush (bubble insert), a valid bit and a saturating bubble counter.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [1:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [1:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RA_W-1:0]   ex_rs,
    output logic [RA_W-1:0]   ex_rt,
    output logic [RA_W-1:0]   ex_rd,
    output logic [5:0]        ex_func,
    output logic [RA_W-1:0]   ex_dest,
    output logic [CNT_W-1:0]  bubble_cnt
);
    localparam int NCTRL = 8;

    logic [NCTRL-1:0]  ctrl_in;
    logic [NCTRL-1:0]  ctrl_next;
    logic [NCTRL-1:0]  ctrl_reg;
    logic [1:0]        alu_op_next;
    logic [1:0]        alu_op_reg;
    logic [RA_W-1:0]   dest_next;
    logic [RA_W-1:0]   dest_reg;
    logic [DATA_W-1:0] pc4_reg;
    logic [DATA_W-1:0] rd1_reg;
    logic [DATA_W-1:0] rd2_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [RA_W-1:0]   rs_reg;
    logic [RA_W-1:0]   rt_reg;
    logic [RA_W-1:0]   rd_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              hold;
    logic              bubble;

    // Flush wins over stall so a stale instruction is never re-executed.
    assign hold   = stall & ~flush;
    assign bubble = flush | (~stall & ~id_valid);

    assign ctrl_in = {id_valid, id_reg_write, id_mem_to_reg, id_mem_read,
                      id_mem_write, id_branch, id_alu_src, id_reg_dst};

    generate
        for (genvar gi = 0; gi < NCTRL; gi++) begin : g_ctrl
            assign ctrl_next[gi] = hold ? ctrl_reg[gi] : (~bubble & ctrl_in[gi]);
        end
    endgenerate

    assign alu_op_next = hold ? alu_op_reg : (bubble ? 2'b00 : id_alu_op);
    // Destination mux sits before the register so EX sees no extra mux delay.
    assign dest_next   = hold ? dest_reg :
                         (bubble ? '0 : (id_reg_dst ? id_rd : id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg   <= '0;
            alu_op_reg <= 2'b00;
            dest_reg   <= '0;
            pc4_reg    <= '0;
            rd1_reg    <= '0;
            rd2_reg    <= '0;
            imm_reg    <= '0;
            rs_reg     <= '0;
            rt_reg     <= '0;
            rd_reg     <= '0;
            cnt_reg    <= '0;
        end else begin
            ctrl_reg   <= ctrl_next;
            alu_op_reg <= alu_op_next;
            dest_reg   <= dest_next;
            if (!hold) begin
                pc4_reg <= id_pc4;
                rd1_reg <= id_rd1;
                rd2_reg <= id_rd2;
                imm_reg <= id_imm;
                rs_reg  <= id_rs;
                rt_reg  <= id_rt;
                rd_reg  <= id_rd;
            end
            if (bubble && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read,
            ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst} = ctrl_reg;
    assign ex_alu_op  = alu_op_reg;
    assign ex_pc4     = pc4_reg;
    assign ex_rd1     = rd1_reg;
    assign ex_rd2     = rd2_reg;
    assign ex_imm     = imm_reg;
    assign ex_rs      = rs_reg;
    assign ex_rt      = rt_reg;
    assign ex_rd      = rd_reg;
    assign ex_func    = imm_reg[5:0];
    assign ex_dest    = dest_reg;
    assign bubble_cnt = cnt_reg;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed steps followed by a random control stream,
// checked against a transaction-level model of the stage.
module tb_id_ex_pipe_reg;
    logic clk = 1'b0;
    logic rst_n, stall, flush;
    logic id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
    logic id_branch, id_alu_src, id_reg_dst;
    logic [1:0]  id_alu_op;
    logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;

    logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic ex_branch, ex_alu_src, ex_reg_dst;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_dest;
    logic [5:0]  ex_func;
    logic [15:0] bubble_cnt;

    logic s_valid, s_reg_write, s_mem_to_reg, s_mem_read, s_mem_write;
    logic s_branch, s_alu_src, s_reg_dst;
    logic [1:0]  s_alu_op;
    logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd, s_dest;
    logic [5:0]  s_func;
    logic [3:0]  s_bubble_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic valid, rw, m2r, mr, mw, br, asrc, rdst;
        logic [1:0]  aop;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd, dest;
        int          bubbles;
    } exp_t;
    exp_t e;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_func(ex_func),
        .ex_dest(ex_dest), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(s_valid), .ex_reg_write(s_reg_write), .ex_mem_to_reg(s_mem_to_reg),
        .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write), .ex_branch(s_branch),
        .ex_alu_src(s_alu_src), .ex_reg_dst(s_reg_dst), .ex_alu_op(s_alu_op),
        .ex_pc4(s_pc4), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_func(s_func),
        .ex_dest(s_dest), .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        e = '{default: '0};
    endtask

    // One clock edge of the stage as seen from the pipeline's point of view.
    task automatic model_edge();
        bit is_bubble;
        is_bubble = flush || (!stall && !id_valid);
        if (is_bubble || !stall) begin
            e.pc4 = id_pc4; e.rd1 = id_rd1; e.rd2 = id_rd2; e.imm = id_imm;
            e.rs = id_rs; e.rt = id_rt; e.rd = id_rd;
        end
        if (is_bubble) begin
            e.valid = 0; e.rw = 0; e.m2r = 0; e.mr = 0; e.mw = 0; e.br = 0;
            e.asrc = 0; e.rdst = 0; e.aop = 2'b00; e.dest = 5'd0;
            e.bubbles++;
        end else if (!stall) begin
            e.valid = id_valid; e.rw = id_reg_write; e.m2r = id_mem_to_reg;
            e.mr = id_mem_read; e.mw = id_mem_write; e.br = id_branch;
            e.asrc = id_alu_src; e.rdst = id_reg_dst; e.aop = id_alu_op;
            e.dest = id_reg_dst ? id_rd : id_rt;
        end
    endtask

    task automatic check_all();
        chk("valid", ex_valid, e.valid);
        chk("reg_write", ex_reg_write, e.rw);
        chk("mem_to_reg", ex_mem_to_reg, e.m2r);
        chk("mem_read", ex_mem_read, e.mr);
        chk("mem_write", ex_mem_write, e.mw);
        chk("branch", ex_branch, e.br);
        chk("alu_src", ex_alu_src, e.asrc);
        chk("reg_dst", ex_reg_dst, e.rdst);
        chk("alu_op", ex_alu_op, e.aop);
        chk("pc4", ex_pc4, e.pc4);
        chk("rd1", ex_rd1, e.rd1);
        chk("rd2", ex_rd2, e.rd2);
        chk("imm", ex_imm, e.imm);
        chk("func", ex_func, e.imm % 64);
        chk("rs", ex_rs, e.rs);
        chk("rt", ex_rt, e.rt);
        chk("rd", ex_rd, e.rd);
        chk("dest", ex_dest, e.dest);
        chk("bubble_cnt", bubble_cnt, sat(e.bubbles, 65535));
        chk("sat_dest", s_dest, e.dest);
        chk("sat_valid", s_valid, e.valid);
        chk("sat_bubble_cnt", s_bubble_cnt, sat(e.bubbles, 15));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_in();
        id_valid      = ($urandom % 8) != 0;
        id_reg_write  = $urandom_range(0, 1);
        id_mem_to_reg = $urandom_range(0, 1);
        id_mem_read   = $urandom_range(0, 1);
        id_mem_write  = $urandom_range(0, 1);
        id_branch     = $urandom_range(0, 1);
        id_alu_src    = $urandom_range(0, 1);
        id_reg_dst    = $urandom_range(0, 1);
        id_alu_op     = 2'($urandom_range(0, 3));
        id_pc4        = $urandom;
        id_rd1        = $urandom;
        id_rd2        = $urandom;
        id_imm        = $urandom;
        id_rs         = 5'($urandom_range(0, 31));
        id_rt         = 5'($urandom_range(0, 31));
        id_rd         = 5'($urandom_range(0, 31));
    endtask

    initial begin
        int base;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        rand_in();
        model_reset();
        #1;
        check_all();
        $display("reset: outputs cleared at start");
        @(negedge clk);
        rst_n = 1'b1;

        // R-type add pass-through
        rand_in();
        id_valid = 1; id_reg_write = 1; id_mem_to_reg = 0; id_mem_read = 0; id_mem_write = 0;
        id_branch = 0; id_alu_src = 0; id_reg_dst = 1; id_alu_op = 2'b10;
        id_imm = 32'h0000_0020; id_rd = 5'd5; id_rt = 5'd3;
        tick();
        chk("rtype_func", ex_func, 6'h20);
        chk("rtype_dest", ex_dest, 5'd5);
        chk("rtype_rw", ex_reg_write, 1'b1);
        chk("rtype_valid", ex_valid, 1'b1);
        $display("pass-through: func=%0h dest=%0d", ex_func, ex_dest);

        // Asynchronous reset mid-cycle with live state
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        $display("mid-cycle reset: valid=%0b cnt=%0d", ex_valid, bubble_cnt);
        @(negedge clk);
        rst_n = 1'b1;

        // lw capture, then a 3-cycle stall with changing ID inputs
        rand_in();
        id_valid = 1; id_reg_write = 1; id_mem_to_reg = 1; id_mem_read = 1; id_mem_write = 0;
        id_branch = 0; id_alu_src = 1; id_reg_dst = 0; id_alu_op = 2'b00; id_rt = 5'd8;
        tick();
        chk("lw_dest", ex_dest, 5'd8);
        $display("lw captured: dest=%0d", ex_dest);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            id_valid = 1;
            tick();
            chk("stall_dest", ex_dest, 5'd8);
            chk("stall_mem_read", ex_mem_read, 1'b1);
            $display("stall cycle %0d: dest=%0d", i, ex_dest);
        end
        stall = 1'b0;
        tick();
        $display("stall released: dest=%0d", ex_dest);

        // Flush during stall with a valid beq in ID
        base = e.bubbles;
        rand_in();
        stall = 1'b1; flush = 1'b1;
        id_valid = 1; id_branch = 1; id_alu_op = 2'b01; id_reg_write = 0;
        tick();
        chk("flush_valid", ex_valid, 1'b0);
        chk("flush_branch", ex_branch, 1'b0);
        chk("flush_alu_op", ex_alu_op, 2'b00);
        chk("flush_cnt", bubble_cnt, 16'(base + 1));
        $display("flush+stall: bubble_cnt=%0d", bubble_cnt);
        stall = 1'b0;

        // 20 bubbles: the 4-bit counter must pin at 15
        for (int i = 0; i < 20; i++) begin
            rand_in();
            tick();
        end
        chk("sat_stop", s_bubble_cnt, 4'd15);
        $display("saturation: narrow cnt=%0d wide cnt=%0d", s_bubble_cnt, bubble_cnt);
        flush = 1'b0;

        // id_valid=0 with no stall/flush is a bubble
        base = e.bubbles;
        rand_in();
        id_valid = 0; id_reg_write = 1; id_mem_write = 1; id_alu_op = 2'b11;
        tick();
        chk("invalid_rw", ex_reg_write, 1'b0);
        chk("invalid_mw", ex_mem_write, 1'b0);
        chk("invalid_cnt", bubble_cnt, 16'(base + 1));
        $display("id_valid=0: bubble_cnt=%0d", bubble_cnt);

        // Random control stream
        for (int i = 0; i < 1000; i++) begin
            rand_in();
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 8) == 0;
            tick();
            if (i % 100 == 0)
                $display("random cycle %0d: stall=%0b flush=%0b valid=%0b cnt=%0d",
                         i, stall, flush, ex_valid, bubble_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
